// File: rtl/pulse_cfg_pkg.sv
// Shared definitions for the pulse configuration controller: register
// addresses, response codes, FSM state encoding and the parameter set type.
package pulse_cfg_pkg;

  localparam logic [7:0] ADDR_PERIOD    = 8'h01;
  localparam logic [7:0] ADDR_P1WIDTH   = 8'h02;
  localparam logic [7:0] ADDR_DELAY     = 8'h03;
  localparam logic [7:0] ADDR_P2WIDTH   = 8'h04;
  localparam logic [7:0] ADDR_BLOCK_LEN = 8'h05;
  localparam logic [7:0] ADDR_BLOCK_OFF = 8'h06;
  localparam logic [7:0] ADDR_CPMG      = 8'h07;
  localparam logic [7:0] ADDR_PUMP      = 8'h08;
  localparam logic [7:0] ADDR_BLK       = 8'h09;
  localparam logic [7:0] ADDR_PRE_ATT   = 8'h0A;
  localparam logic [7:0] ADDR_POST_ATT  = 8'h0B;
  localparam logic [7:0] ADDR_APPLY     = 8'h0F;

  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_e;

  // One complete pulse parameter set (used for both shadow and active copies).
  typedef struct packed {
    logic [31:0] period;
    logic [31:0] p1width;
    logic [31:0] delay;
    logic [31:0] p2width;
    logic [7:0]  pulse_block;
    logic [15:0] pulse_block_off;
    logic [7:0]  cpmg;
    logic        pump;
    logic        block;
    logic [6:0]  pre_att;
    logic [6:0]  post_att;
  } cfg_t;

endpackage

// File: rtl/pulse_cfg_if.sv
// Byte stream between the UART and the controller.
//   rx_data/rx_valid : received byte with one-cycle strobe (UART -> ctrl)
//   tx_data/tx_valid : response byte, held until accepted (ctrl -> UART)
//   tx_ready         : transmitter accepts the response byte
interface pulse_cfg_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/pulse_cfg_parser.sv
// Frame assembler: latches the address byte, shifts in four big-endian value
// bytes and watches the gap between bytes.
//   clk, resetn        : clock, synchronous active-low reset
//   rx_data_i/rx_valid_i : received byte stream
//   idle_i/data_i      : controller FSM is in IDLE / DATA
//   addr_o/value_o     : assembled frame contents
//   frame_valid_o      : last value byte is being accepted this cycle
//   timeout_o          : inter-byte gap expires this cycle
module pulse_cfg_parser #(
  parameter logic [31:0] TIMEOUT = 32'd120000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        idle_i,
  input  logic        data_i,
  output logic [7:0]  addr_o,
  output logic [31:0] value_o,
  output logic        frame_valid_o,
  output logic        timeout_o
);

  logic [7:0]  addr_q;
  logic [31:0] value_q;
  logic [2:0]  cnt_q;
  logic [31:0] idle_cnt_q;

  assign addr_o        = addr_q;
  assign value_o       = value_q;
  assign frame_valid_o = data_i && rx_valid_i && (cnt_q == 3'd3);
  // The TIMEOUT-th consecutive idle cycle ends the frame.
  assign timeout_o     = data_i && !rx_valid_i && (idle_cnt_q == TIMEOUT - 32'd1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q     <= '0;
      value_q    <= '0;
      cnt_q      <= '0;
      idle_cnt_q <= '0;
    end else if (idle_i && rx_valid_i) begin
      addr_q     <= rx_data_i;
      value_q    <= '0;
      cnt_q      <= '0;
      idle_cnt_q <= '0;
    end else if (data_i) begin
      if (rx_valid_i) begin
        value_q    <= {value_q[23:0], rx_data_i};
        cnt_q      <= cnt_q + 3'd1;
        idle_cnt_q <= '0;
      end else begin
        idle_cnt_q <= idle_cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: rtl/pulse_cfg_ctrl.sv
// Pulse parameter controller: UART frames write a shadow register set, an
// apply command arms it, and the set is copied to the active outputs on the
// next period_start so parameters only change at a period boundary.
//   clk, resetn     : clock, synchronous active-low reset
//   bus             : rx byte stream in, response byte out
//   period_start    : one-cycle strobe at the start of each pulse period
//   period..post_att: active pulse parameters
//   pending         : shadow set armed for commit
//   frame_err       : one-cycle strobe on timeout or NAK
module pulse_cfg_ctrl
  import pulse_cfg_pkg::*;
#(
  parameter logic [31:0] TIMEOUT       = 32'd120000,
  parameter logic [31:0] DEF_PERIOD    = 32'd20000,
  parameter logic [31:0] DEF_P1WIDTH   = 32'd30,
  parameter logic [31:0] DEF_DELAY     = 32'd200,
  parameter logic [31:0] DEF_P2WIDTH   = 32'd60,
  parameter logic [7:0]  DEF_BLOCK     = 8'd50,
  parameter logic [15:0] DEF_BLOCKOFF  = 16'd100,
  parameter logic [7:0]  DEF_CPMG      = 8'd10,
  parameter logic        DEF_PUMP      = 1'b1,
  parameter logic        DEF_BLK       = 1'b1,
  parameter logic [6:0]  DEF_PRE_ATT   = 7'h00,
  parameter logic [6:0]  DEF_POST_ATT  = 7'h7F
) (
  input  logic              clk,
  input  logic              resetn,
  pulse_cfg_if.slave        bus,
  input  logic              period_start,
  output logic [31:0]       period,
  output logic [31:0]       p1width,
  output logic [31:0]       delay,
  output logic [31:0]       p2width,
  output logic [7:0]        pulse_block,
  output logic [15:0]       pulse_block_off,
  output logic [7:0]        cpmg,
  output logic              pump,
  output logic              block,
  output logic [6:0]        pre_att,
  output logic [6:0]        post_att,
  output logic              pending,
  output logic              frame_err
);

  localparam cfg_t DEF_CFG = '{DEF_PERIOD, DEF_P1WIDTH, DEF_DELAY, DEF_P2WIDTH,
                               DEF_BLOCK, DEF_BLOCKOFF, DEF_CPMG, DEF_PUMP,
                               DEF_BLK, DEF_PRE_ATT, DEF_POST_ATT};

  state_e      state_q;
  cfg_t        shadow_q, active_q, shadow_d;
  logic        pending_q, frame_err_q, tx_valid_q;
  logic [7:0]  tx_data_q;
  logic [7:0]  frame_addr;
  logic [31:0] frame_value;
  logic        frame_valid, frame_timeout;
  logic        is_reg, is_apply, cmd_ok;

  pulse_cfg_parser #(.TIMEOUT(TIMEOUT)) u_parser (
    .clk          (clk),
    .resetn       (resetn),
    .rx_data_i    (bus.rx_data),
    .rx_valid_i   (bus.rx_valid),
    .idle_i       (state_q == IDLE),
    .data_i       (state_q == DATA),
    .addr_o       (frame_addr),
    .value_o      (frame_value),
    .frame_valid_o(frame_valid),
    .timeout_o    (frame_timeout)
  );

  // Decode the assembled frame; a period below 2 is rejected.
  assign is_reg   = (frame_addr >= ADDR_PERIOD) && (frame_addr <= ADDR_POST_ATT);
  assign is_apply = (frame_addr == ADDR_APPLY);
  assign cmd_ok   = is_apply ||
                    (is_reg && !((frame_addr == ADDR_PERIOD) && (frame_value < 32'd2)));

  always_comb begin
    shadow_d = shadow_q;
    case (frame_addr)
      ADDR_PERIOD:    shadow_d.period          = frame_value;
      ADDR_P1WIDTH:   shadow_d.p1width         = frame_value;
      ADDR_DELAY:     shadow_d.delay           = frame_value;
      ADDR_P2WIDTH:   shadow_d.p2width         = frame_value;
      ADDR_BLOCK_LEN: shadow_d.pulse_block     = frame_value[7:0];
      ADDR_BLOCK_OFF: shadow_d.pulse_block_off = frame_value[15:0];
      ADDR_CPMG:      shadow_d.cpmg            = frame_value[7:0];
      ADDR_PUMP:      shadow_d.pump            = frame_value[0];
      ADDR_BLK:       shadow_d.block           = frame_value[0];
      ADDR_PRE_ATT:   shadow_d.pre_att         = frame_value[6:0];
      ADDR_POST_ATT:  shadow_d.post_att        = frame_value[6:0];
      default:        ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      shadow_q    <= DEF_CFG;
      active_q    <= DEF_CFG;
      pending_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      frame_err_q <= 1'b0;
      // Commit reads the registered shadow, so a write landing in the same
      // cycle is only picked up by a later commit.
      if (period_start && pending_q) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (bus.rx_valid) state_q <= DATA;
        DATA: begin
          if (frame_valid) begin
            state_q <= EXEC;
          end else if (frame_timeout) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
          end
        end
        EXEC: begin
          state_q    <= RESP;
          tx_valid_q <= 1'b1;
          if (cmd_ok) begin
            tx_data_q <= RESP_ACK;
            // Arming overrides a commit in this same cycle; the newly armed
            // set then waits for the following period_start.
            if (is_apply) pending_q <= 1'b1;
            else          shadow_q  <= shadow_d;
          end else begin
            tx_data_q   <= RESP_NAK;
            frame_err_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign period          = active_q.period;
  assign p1width         = active_q.p1width;
  assign delay           = active_q.delay;
  assign p2width         = active_q.p2width;
  assign pulse_block     = active_q.pulse_block;
  assign pulse_block_off = active_q.pulse_block_off;
  assign cpmg            = active_q.cpmg;
  assign pump            = active_q.pump;
  assign block           = active_q.block;
  assign pre_att         = active_q.pre_att;
  assign post_att        = active_q.post_att;
  assign pending         = pending_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_pulse_cfg_ctrl.sv
// Self-checking bench for pulse_cfg_ctrl. Expected response bytes are queued
// as frames are sent and compared by a monitor when the DUT transfers them.
module tb_pulse_cfg_ctrl;
  import pulse_cfg_pkg::*;

  localparam int TO = 40;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic period_start = 1'b0;
  logic [31:0] period, p1width, delay, p2width;
  logic [7:0]  pulse_block, cpmg;
  logic [15:0] pulse_block_off;
  logic        pump, block, pending, frame_err;
  logic [6:0]  pre_att, post_att;

  pulse_cfg_if bus();

  always #5 clk = ~clk;

  pulse_cfg_ctrl #(.TIMEOUT(32'd40)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave), .period_start(period_start),
    .period(period), .p1width(p1width), .delay(delay), .p2width(p2width),
    .pulse_block(pulse_block), .pulse_block_off(pulse_block_off), .cpmg(cpmg),
    .pump(pump), .block(block), .pre_att(pre_att), .post_att(post_att),
    .pending(pending), .frame_err(frame_err)
  );

  int passed = 0;
  int total = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  // Scoreboard monitor: every transferred response byte is matched in order.
  always @(negedge clk) begin
    if (resetn) begin
      if (frame_err) err_cnt++;
      if (bus.tx_valid && bus.tx_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL resp_unexpected got %02h want none", bus.tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.tx_data !== e)
            $display("FAIL resp_byte got %02h want %02h", bus.tx_data, e);
          else begin
            passed++;
            $display("resp %02h ok", bus.tx_data);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] v, input logic [7:0] r);
    exp_q.push_back(r);
    $display("frame %02h %08h expect %02h", a, v, r);
    send_byte(a);
    for (int i = 3; i >= 0; i--) send_byte(v[8*i +: 8]);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0) $display("FAIL resp_timeout got %0d pending want 0", exp_q.size());
    else passed++;
  endtask

  task automatic pulse_period();
    period_start = 1'b1;
    @(posedge clk); #1;
    period_start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    total++;
    if ({period, p1width, delay, p2width, pulse_block, pulse_block_off, cpmg, pump, block, pre_att, post_att}
        !== {32'd20000, 32'd30, 32'd200, 32'd60, 8'd50, 16'd100, 8'd10, 1'b1, 1'b1, 7'h00, 7'h7F})
      $display("FAIL reset_defaults got %0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d", period, p1width, delay,
               p2width, pulse_block, pulse_block_off, cpmg, pump, block, pre_att, post_att);
    else passed++;
    total++;
    if (period !== 32'd20000 || post_att !== 7'h7F)
      $display("FAIL reset_period got %0d/%02h want 20000/7f", period, post_att);
    else passed++;
    total++;
    if ({pending, bus.tx_valid, frame_err, bus.tx_data} !== 11'd0)
      $display("FAIL reset_flags got %b%b%b %02h want 000 00", pending, bus.tx_valid, frame_err, bus.tx_data);
    else passed++;
  endtask

  task automatic test_apply();
    send_frame(ADDR_PERIOD, 32'h0000_2710, RESP_ACK); drain();
    send_frame(ADDR_APPLY, 32'h0, RESP_ACK); drain();
    total++;
    if (pending !== 1'b1 || period !== 32'd20000)
      $display("FAIL apply_armed got %b/%0d want 1/20000", pending, period);
    else passed++;
    period_start = 1'b1;
    @(negedge clk);
    total++;
    if (period !== 32'd20000) $display("FAIL apply_early got %0d want 20000", period);
    else passed++;
    @(posedge clk); #1;
    period_start = 1'b0;
    total++;
    if (period !== 32'd10000 || pending !== 1'b0)
      $display("FAIL apply_commit got %0d/%b want 10000/0", period, pending);
    else passed++;
  endtask

  task automatic test_nak();
    int e0 = err_cnt;
    send_frame(8'h22, 32'h1, RESP_NAK); drain();
    send_frame(ADDR_PERIOD, 32'h1, RESP_NAK); drain();
    total++;
    if (err_cnt !== e0 + 2) $display("FAIL nak_err got %0d want %0d", err_cnt, e0 + 2);
    else passed++;
    send_frame(ADDR_APPLY, 32'h0, RESP_ACK); drain();
    pulse_period();
    total++;
    if (period !== 32'd10000) $display("FAIL nak_shadow got %0d want 10000", period);
    else passed++;
  endtask

  task automatic test_timeout();
    int e0 = err_cnt;
    send_byte(ADDR_P1WIDTH); send_byte(8'h00);
    repeat (TO + 3) @(posedge clk);
    #1;
    total++;
    if (err_cnt !== e0 + 1 || bus.tx_valid !== 1'b0)
      $display("FAIL timeout_err got %0d/%b want %0d/0", err_cnt, bus.tx_valid, e0 + 1);
    else passed++;
    // A gap one cycle short of the limit must not break the frame.
    exp_q.push_back(RESP_ACK);
    send_byte(ADDR_P1WIDTH); send_byte(8'h00);
    repeat (TO - 1) @(posedge clk);
    #1;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h28);
    drain();
    send_frame(ADDR_APPLY, 32'h0, RESP_ACK); drain();
    pulse_period();
    total++;
    if (p1width !== 32'd40 || err_cnt !== e0 + 1)
      $display("FAIL timeout_recover got %0d/%0d want 40/%0d", p1width, err_cnt, e0 + 1);
    else passed++;
  endtask

  task automatic test_all_fields();
    send_frame(ADDR_DELAY,     32'h0000_1234, RESP_ACK); drain();
    send_frame(ADDR_P2WIDTH,   32'hABCD_0001, RESP_ACK); drain();
    send_frame(ADDR_BLOCK_LEN, 32'h1234_5678, RESP_ACK); drain();
    send_frame(ADDR_BLOCK_OFF, 32'h1234_5678, RESP_ACK); drain();
    send_frame(ADDR_CPMG,      32'h0000_01FF, RESP_ACK); drain();
    send_frame(ADDR_PUMP,      32'h0000_0002, RESP_ACK); drain();
    send_frame(ADDR_BLK,       32'hFFFF_FFFE, RESP_ACK); drain();
    send_frame(ADDR_PRE_ATT,   32'h0000_01FF, RESP_ACK); drain();
    send_frame(ADDR_POST_ATT,  32'h0000_0080, RESP_ACK); drain();
    total++;
    if (delay !== 32'd200 || cpmg !== 8'd10 || pending !== 1'b0)
      $display("FAIL fields_early got %0d/%0d/%b want 200/10/0", delay, cpmg, pending);
    else passed++;
    send_frame(ADDR_APPLY, 32'h0, RESP_ACK); drain();
    pulse_period();
    total++;
    if ({delay, p2width, pulse_block, pulse_block_off, cpmg, pump, block, pre_att, post_att}
        !== {32'h1234, 32'hABCD_0001, 8'h78, 16'h5678, 8'hFF, 1'b0, 1'b0, 7'h7F, 7'h00})
      $display("FAIL fields_commit got %h/%h/%h/%h/%h/%b/%b/%h/%h", delay, p2width, pulse_block,
               pulse_block_off, cpmg, pump, block, pre_att, post_att);
    else passed++;
  endtask

  task automatic test_coincident();
    send_frame(ADDR_DELAY, 32'h777, RESP_ACK); drain();
    // Apply whose EXEC cycle coincides with period_start.
    exp_q.push_back(RESP_ACK);
    send_byte(ADDR_APPLY);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    pulse_period();
    total++;
    if (delay !== 32'h1234 || pending !== 1'b1)
      $display("FAIL coinc_apply got %h/%b want 1234/1", delay, pending);
    else passed++;
    drain();
    pulse_period();
    total++;
    if (delay !== 32'h777) $display("FAIL coinc_next got %h want 777", delay);
    else passed++;
    // Shadow write coinciding with commit: commit takes the older value.
    send_frame(ADDR_DELAY, 32'h100, RESP_ACK); drain();
    send_frame(ADDR_APPLY, 32'h0, RESP_ACK); drain();
    send_frame(ADDR_APPLY, 32'h0, RESP_ACK); drain();
    exp_q.push_back(RESP_ACK);
    send_byte(ADDR_DELAY); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00);
    pulse_period();
    total++;
    if (delay !== 32'h100 || pending !== 1'b0)
      $display("FAIL coinc_write got %h/%b want 100/0", delay, pending);
    else passed++;
    drain();
    send_frame(ADDR_APPLY, 32'h0, RESP_ACK); drain();
    pulse_period();
    total++;
    if (delay !== 32'h200) $display("FAIL coinc_later got %h want 200", delay);
    else passed++;
  endtask

  task automatic test_stall();
    int n = 0;
    bit stable = 1'b1;
    bus.tx_ready = 1'b0;
    send_frame(ADDR_CPMG, 32'h5, RESP_ACK);
    while (!bus.tx_valid && n < 20) begin @(posedge clk); #1; n++; end
    send_byte(8'h01);  // dropped while a response is outstanding
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== RESP_ACK) stable = 1'b0;
    end
    total++;
    if (!stable) $display("FAIL stall_stable got %b/%02h want 1/06", bus.tx_valid, bus.tx_data);
    else passed++;
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;
    drain();
    send_frame(ADDR_CPMG, 32'h9, RESP_ACK); drain();
    send_frame(ADDR_APPLY, 32'h0, RESP_ACK); drain();
    pulse_period();
    total++;
    if (cpmg !== 8'd9 || period !== 32'd10000)
      $display("FAIL stall_drop got %0d/%0d want 9/10000", cpmg, period);
    else passed++;
    // Reset while a response is held.
    bus.tx_ready = 1'b0;
    send_frame(ADDR_BLOCK_LEN, 32'h3, RESP_ACK);
    n = 0;
    while (!bus.tx_valid && n < 20) begin @(posedge clk); #1; n++; end
    resetn = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.tx_valid !== 1'b0) $display("FAIL rst_resp got %b want 0", bus.tx_valid);
    else passed++;
    exp_q.delete();
    resetn = 1'b1;
    bus.tx_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (bus.tx_valid !== 1'b0 || pending !== 1'b0 || cpmg !== 8'd10 || period !== 32'd20000)
      $display("FAIL rst_state got %b/%b/%0d/%0d want 0/0/10/20000", bus.tx_valid, pending, cpmg, period);
    else passed++;
  endtask

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    #1;
    test_reset();
    test_apply();
    test_nak();
    test_timeout();
    test_all_fields();
    test_coincident();
    test_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench time limit");
  end

endmodule
